mc_control_fsm: RTL and testbench
=================================

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 SHALL have parameter MEM_HANDSHAKE, default 1, meaning 1 = memory states wait for mem_ready_i and 0 = memory always completes in one cycle.
REQ-002 SHALL have parameter SUPPORT_U, default 1, meaning 1 = LUI/AUIPC legal and 0 = LUI/AUIPC treated as illegal.
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 SHALL have port clk_i, input, 1, clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1, synchronous active-low reset.
REQ-006 SHALL have port op_i, input, 7, opcode field of the instruction register.
REQ-007 SHALL have port mem_ready_i, input, 1, memory access completes this cycle.
REQ-008 SHALL have ports pc_write_o (1), ir_write_o (1), reg_write_o (1), mem_write_o (1), mem_req_o (1), branch_o (1), adr_src_o (1), all outputs with the usual datapath meaning.
REQ-009 SHALL have ports result_src_o (2), alu_src_a_o (2), alu_src_b_o (2), alu_op_o (2), imm_src_o (3), all outputs selecting datapath muxes and ALU mode.
REQ-010 SHALL have port state_o, output, 4, current state code; and port illegal_o, output, 1, sticky illegal-opcode flag.

Function
REQ-011 SHALL implement a Moore FSM with state codes FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, JALR_TGT=11, LUI=12, AUIPC=13, TRAP=14; code 15 SHALL go to FETCH.
REQ-012 SHALL use these encodings: alu_src_a 00=PC, 01=oldPC, 10=rs1, 11=zero; alu_src_b 00=rs2, 01=imm, 10=const 4; result_src 00=ALUOut, 01=mem data, 10=ALU direct.
REQ-013 SHALL drive imm_src_o combinationally from op_i in every state: I/load/JALR=000, store=001, branch=010, U=011, JAL=100, others=000.
REQ-014 In FETCH, SHALL assert mem_req_o, with adr_src=0, a=00, b=10, alu_op=00 and result_src=10; ir_write_o and pc_write_o SHALL assert only in the cycle the access completes, then go to DECODE.
REQ-015 An access in FETCH, MEMREAD or MEMWRITE SHALL complete when mem_ready_i=1 (MEM_HANDSHAKE=1) or unconditionally (MEM_HANDSHAKE=0); otherwise the FSM SHALL hold state and outputs.
REQ-016 In DECODE, SHALL use a=01, b=01, alu_op=00, and branch on op_i: load/store->MEMADR, R->EXECR, I-ALU->EXECI, branch->BRANCH, JAL->JAL, JALR->JALR_TGT, LUI->LUI, AUIPC->AUIPC, and any other opcode->TRAP.
REQ-017 In MEMADR, SHALL use a=10, b=01, alu_op=00, then go to MEMREAD if op_i=0000011, else to MEMWRITE.
REQ-018 In MEMREAD, SHALL assert mem_req_o with adr_src=1, then go to MEMWB on completion; MEMWB SHALL use result_src=01 and reg_write=1, then go to FETCH.
REQ-019 In MEMWRITE, SHALL assert mem_req_o, adr_src=1 and mem_write_o, with mem_write_o held high while waiting, then go to FETCH on completion.
REQ-020 EXECR SHALL use a=10, b=00, alu_op=10; EXECI SHALL use a=10, b=01, alu_op=10; both then go to ALUWB.
REQ-021 ALUWB SHALL use result_src=00 and reg_write=1, then go to FETCH.
REQ-022 BRANCH SHALL use a=10, b=00, alu_op=01, result_src=00 and branch_o=1, then go to FETCH.
REQ-023 JALR_TGT SHALL use a=10, b=01, alu_op=00, then go to JAL.
REQ-024 JAL SHALL use a=01, b=10, alu_op=00, result_src=00 and pc_write=1, then go to ALUWB.
REQ-025 LUI SHALL use a=11, b=01; AUIPC SHALL use a=01, b=01; both SHALL use alu_op=00 and then go to ALUWB.
REQ-026 With SUPPORT_U=0, DECODE SHALL send LUI/AUIPC opcodes to TRAP.
REQ-027 TRAP SHALL hold all enables at 0, set illegal_o=1, and remain in TRAP until reset.
REQ-028 In any state not listed for a signal, every enable SHALL be 0 and every select SHALL be 00/000.

Reset
REQ-029 While rst_ni=0 at a clock edge, state SHALL become FETCH and illegal_o SHALL become 0.
REQ-030 During any cycle with rst_ni=0, pc_write, ir_write, reg_write, mem_write, mem_req and branch SHALL be forced to 0.
REQ-031 Reset SHALL abort any state, including a pending memory wait, with no completion side-effects.

Verification
REQ-032 R-type: op=0110011, ready=1 -> states 0,1,6,8,0; reg_write=1 only in state 8.
REQ-033 Load with wait: op=0000011, ready low 2 cycles in MEMREAD -> state 3 for 3 cycles with mem_req=1 and adr_src=1; then state 4 with result_src=01 and reg_write=1.
REQ-034 JALR: op=1100111 -> states 0,1,11,10,8; pc_write=1 in 10; imm_src=000 throughout.
REQ-035 FETCH stall: ready=0 for 4 cycles -> ir_write=0 and pc_write=0 until ready=1, which gives a single-cycle pulse of both.
REQ-036 Illegal op=1111111, then SUPPORT_U=0 with op=0110111 -> TRAP (14), illegal_o=1 held; rst_ni=0 -> state 0 and illegal_o=0.
REQ-037 Store with rst_ni=0 asserted mid-MEMWRITE while ready=0 -> next state 0, and mem_write=0 during the reset cycle.

Source files
------------

// File: rtl/mc_control_fsm_if.sv
// Control bus between the multi-cycle controller and its datapath.
// The controller connects to the master side and the datapath to the slave side.
interface mc_control_fsm_if;
  logic [6:0] op_i;
  logic       mem_ready_i;
  logic       pc_write_o;
  logic       ir_write_o;
  logic       reg_write_o;
  logic       mem_write_o;
  logic       mem_req_o;
  logic       branch_o;
  logic       adr_src_o;
  logic [1:0] result_src_o;
  logic [1:0] alu_src_a_o;
  logic [1:0] alu_src_b_o;
  logic [1:0] alu_op_o;
  logic [2:0] imm_src_o;
  logic [3:0] state_o;
  logic       illegal_o;

  modport master (
    input  op_i, mem_ready_i,
    output pc_write_o, ir_write_o, reg_write_o, mem_write_o, mem_req_o,
           branch_o, adr_src_o, result_src_o, alu_src_a_o, alu_src_b_o,
           alu_op_o, imm_src_o, state_o, illegal_o
  );

  modport slave (
    output op_i, mem_ready_i,
    input  pc_write_o, ir_write_o, reg_write_o, mem_write_o, mem_req_o,
           branch_o, adr_src_o, result_src_o, alu_src_a_o, alu_src_b_o,
           alu_op_o, imm_src_o, state_o, illegal_o
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle RISC-V style main controller: Moore FSM sequencing fetch,
// decode, memory, ALU, branch and jump steps, with a sticky illegal-opcode trap.
module mc_control_fsm #(
  parameter int MEM_HANDSHAKE = 1,
  parameter int SUPPORT_U     = 1
) (
  input logic         clk_i,
  input logic         rst_ni,
  mc_control_fsm_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR_TGT = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  state_t state_q, state_d;
  logic   illegal_q;
  logic   mem_done;

  logic pc_write, ir_write, reg_write, mem_write, mem_req, branch, adr_src;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;

  assign mem_done = (MEM_HANDSHAKE != 0) ? bus.mem_ready_i : 1'b1;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == S_TRAP) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    mem_req    = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    result_src = '0;
    alu_src_a  = '0;
    alu_src_b  = '0;
    alu_op     = '0;
    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_done) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (bus.op_i)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR_TGT;
          OP_LUI:            state_d = (SUPPORT_U != 0) ? S_LUI : S_TRAP;
          OP_AUIPC:          state_d = (SUPPORT_U != 0) ? S_AUIPC : S_TRAP;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (bus.op_i == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_done) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_done) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JALR_TGT: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = S_JAL;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = S_ALUWB;
      end
      S_LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
        state_d   = S_ALUWB;
      end
      S_AUIPC: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        state_d   = S_ALUWB;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    case (bus.op_i)
      OP_STORE:          bus.imm_src_o = 3'b001;
      OP_BRANCH:         bus.imm_src_o = 3'b010;
      OP_LUI, OP_AUIPC:  bus.imm_src_o = 3'b011;
      OP_JAL:            bus.imm_src_o = 3'b100;
      default:           bus.imm_src_o = 3'b000;
    endcase
  end

  // Enables are gated by reset so an aborted access leaves no side-effects.
  assign bus.pc_write_o   = pc_write  & rst_ni;
  assign bus.ir_write_o   = ir_write  & rst_ni;
  assign bus.reg_write_o  = reg_write & rst_ni;
  assign bus.mem_write_o  = mem_write & rst_ni;
  assign bus.mem_req_o    = mem_req   & rst_ni;
  assign bus.branch_o     = branch    & rst_ni;
  assign bus.adr_src_o    = adr_src;
  assign bus.result_src_o = result_src;
  assign bus.alu_src_a_o  = alu_src_a;
  assign bus.alu_src_b_o  = alu_src_b;
  assign bus.alu_op_o     = alu_op;
  assign bus.state_o      = state_q;
  assign bus.illegal_o    = illegal_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: walks instruction classes through the FSM
// and checks states and control outputs against hand-computed values.
module tb_mc_control_fsm;
  logic clk = 1'b0;
  logic rst_n;
  logic rst_nu_n;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  mc_control_fsm_if bus ();
  mc_control_fsm_if bus_nu ();

  mc_control_fsm #(.MEM_HANDSHAKE(1), .SUPPORT_U(1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus.master)
  );

  mc_control_fsm #(.MEM_HANDSHAKE(1), .SUPPORT_U(0)) dut_nu (
    .clk_i(clk), .rst_ni(rst_nu_n), .bus(bus_nu.master)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    rst_nu_n = 1'b0;
    bus.op_i = 7'b0110011;
    bus.mem_ready_i = 1'b1;
    bus_nu.op_i = 7'b0110111;
    bus_nu.mem_ready_i = 1'b1;

    // reset state; enables forced low although FETCH sees ready=1
    step();
    check("rst_state", bus.state_o, 0);
    check("rst_illegal", bus.illegal_o, 0);
    check("rst_ir_write", bus.ir_write_o, 0);
    check("rst_pc_write", bus.pc_write_o, 0);
    check("rst_mem_req", bus.mem_req_o, 0);
    rst_n = 1'b1;
    rst_nu_n = 1'b1;

    // R-type: 0,1,6,8,0
    #1;
    check("r_fetch_ir", bus.ir_write_o, 1);
    check("r_fetch_pc", bus.pc_write_o, 1);
    check("r_fetch_req", bus.mem_req_o, 1);
    check("r_fetch_b", bus.alu_src_b_o, 2);
    check("r_fetch_res", bus.result_src_o, 2);
    step();
    check("r_dec_state", bus.state_o, 1);
    check("r_dec_a", bus.alu_src_a_o, 1);
    check("r_dec_b", bus.alu_src_b_o, 1);
    check("r_dec_rw", bus.reg_write_o, 0);
    step();
    check("r_exec_state", bus.state_o, 6);
    check("r_exec_a", bus.alu_src_a_o, 2);
    check("r_exec_b", bus.alu_src_b_o, 0);
    check("r_exec_op", bus.alu_op_o, 2);
    check("r_exec_rw", bus.reg_write_o, 0);
    step();
    check("r_wb_state", bus.state_o, 8);
    check("r_wb_rw", bus.reg_write_o, 1);
    check("r_wb_res", bus.result_src_o, 0);
    step();
    check("r_back_state", bus.state_o, 0);
    check("r_back_rw", bus.reg_write_o, 0);

    // load with two wait cycles in MEMREAD
    bus.op_i = 7'b0000011;
    step();
    check("ld_dec", bus.state_o, 1);
    step();
    check("ld_adr_state", bus.state_o, 2);
    check("ld_adr_a", bus.alu_src_a_o, 2);
    check("ld_adr_b", bus.alu_src_b_o, 1);
    bus.mem_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check("ld_wait_state", bus.state_o, 3);
      check("ld_wait_req", bus.mem_req_o, 1);
      check("ld_wait_adr", bus.adr_src_o, 1);
    end
    bus.mem_ready_i = 1'b1;
    #1;
    check("ld_rd_state", bus.state_o, 3);
    check("ld_rd_req", bus.mem_req_o, 1);
    step();
    check("ld_wb_state", bus.state_o, 4);
    check("ld_wb_res", bus.result_src_o, 1);
    check("ld_wb_rw", bus.reg_write_o, 1);
    step();
    check("ld_back", bus.state_o, 0);

    // JALR: 0,1,11,10,8
    bus.op_i = 7'b1100111;
    #1;
    check("jalr_imm0", bus.imm_src_o, 0);
    step();
    check("jalr_dec", bus.state_o, 1);
    check("jalr_imm1", bus.imm_src_o, 0);
    step();
    check("jalr_tgt", bus.state_o, 11);
    check("jalr_tgt_a", bus.alu_src_a_o, 2);
    check("jalr_tgt_pc", bus.pc_write_o, 0);
    step();
    check("jalr_jal", bus.state_o, 10);
    check("jalr_jal_pc", bus.pc_write_o, 1);
    check("jalr_jal_b", bus.alu_src_b_o, 2);
    check("jalr_imm2", bus.imm_src_o, 0);
    step();
    check("jalr_wb", bus.state_o, 8);
    check("jalr_wb_rw", bus.reg_write_o, 1);
    step();
    check("jalr_back", bus.state_o, 0);

    // FETCH stall for 4 cycles, then a single-cycle write pulse
    bus.op_i = 7'b0110011;
    bus.mem_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("stall_ir", bus.ir_write_o, 0);
      check("stall_pc", bus.pc_write_o, 0);
      check("stall_req", bus.mem_req_o, 1);
      step();
      check("stall_state", bus.state_o, 0);
    end
    bus.mem_ready_i = 1'b1;
    #1;
    check("stall_ir_pulse", bus.ir_write_o, 1);
    check("stall_pc_pulse", bus.pc_write_o, 1);
    step();
    check("stall_dec", bus.state_o, 1);
    check("stall_ir_done", bus.ir_write_o, 0);
    check("stall_pc_done", bus.pc_write_o, 0);
    step();
    step();
    step();
    check("stall_back", bus.state_o, 0);

    // branch: 0,1,9,0
    bus.op_i = 7'b1100011;
    step();
    check("br_imm", bus.imm_src_o, 2);
    step();
    check("br_state", bus.state_o, 9);
    check("br_branch", bus.branch_o, 1);
    check("br_op", bus.alu_op_o, 1);
    check("br_a", bus.alu_src_a_o, 2);
    step();
    check("br_back", bus.state_o, 0);
    check("br_branch_off", bus.branch_o, 0);

    // LUI with U-type support: 0,1,12,8,0
    bus.op_i = 7'b0110111;
    step();
    check("lui_imm", bus.imm_src_o, 3);
    step();
    check("lui_state", bus.state_o, 12);
    check("lui_a", bus.alu_src_a_o, 3);
    check("lui_b", bus.alu_src_b_o, 1);
    step();
    check("lui_wb", bus.state_o, 8);
    step();
    check("lui_back", bus.state_o, 0);

    // store, reset asserted mid-MEMWRITE while not ready
    bus.op_i = 7'b0100011;
    step();
    check("st_imm", bus.imm_src_o, 1);
    step();
    check("st_adr", bus.state_o, 2);
    bus.mem_ready_i = 1'b0;
    step();
    check("st_wr_state", bus.state_o, 5);
    check("st_wr_mw", bus.mem_write_o, 1);
    check("st_wr_req", bus.mem_req_o, 1);
    step();
    check("st_hold_state", bus.state_o, 5);
    check("st_hold_mw", bus.mem_write_o, 1);
    rst_n = 1'b0;
    #1;
    check("st_rst_mw", bus.mem_write_o, 0);
    check("st_rst_req", bus.mem_req_o, 0);
    step();
    check("st_rst_state", bus.state_o, 0);
    rst_n = 1'b1;
    bus.mem_ready_i = 1'b1;

    // illegal opcode traps and stays trapped until reset
    bus.op_i = 7'b1111111;
    step();
    check("ill_dec", bus.state_o, 1);
    check("ill_flag_pre", bus.illegal_o, 0);
    step();
    check("ill_trap", bus.state_o, 14);
    check("ill_flag", bus.illegal_o, 1);
    check("ill_req", bus.mem_req_o, 0);
    bus.op_i = 7'b0110011;
    step();
    step();
    check("ill_hold", bus.state_o, 14);
    check("ill_flag_hold", bus.illegal_o, 1);
    check("ill_pc", bus.pc_write_o, 0);
    rst_n = 1'b0;
    step();
    check("ill_rst_state", bus.state_o, 0);
    check("ill_rst_flag", bus.illegal_o, 0);
    rst_n = 1'b1;

    // SUPPORT_U=0 instance has been running LUI since reset release
    check("nu_trap", bus_nu.state_o, 14);
    check("nu_flag", bus_nu.illegal_o, 1);
    check("nu_imm", bus_nu.imm_src_o, 3);
    rst_nu_n = 1'b0;
    step();
    check("nu_rst_state", bus_nu.state_o, 0);
    check("nu_rst_flag", bus_nu.illegal_o, 0);
    rst_nu_n = 1'b1;
    step();
    check("nu_dec", bus_nu.state_o, 1);
    step();
    check("nu_retrap", bus_nu.state_o, 14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
